led_pulse_stretcher: RTL and testbench

LED_PULSE_STRETCHER -- requirements
Module: led_pulse_stretcher

---
 rtl/led_pkg.sv | 19 +
 rtl/led_stretch_channel.sv | 104 ++++++++++
 rtl/led_pulse_stretcher.sv | 32 +++
 tb/tb_led_pulse_stretcher.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pulse stretcher: channel FSM encodings and
// the down-counter width helper.
package led_pkg;

    typedef logic [1:0] led_state_t;

    localparam led_state_t StIdle = 2'd0;
    localparam led_state_t StOn   = 2'd1;
    localparam led_state_t StGap  = 2'd2;

    // Wide enough to hold the larger of the two reload values without wrapping.
    function automatic int unsigned cnt_width(input int unsigned on_cycles,
                                              input int unsigned gap_cycles);
        int unsigned max_cycles;
        max_cycles = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/led_stretch_channel.sv
// One LED channel: stretches a single-cycle event into a fixed on-time,
// followed by a forced off-gap during which new events are remembered.
module led_stretch_channel
    import led_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 2500000,
    parameter int unsigned GAP_CYCLES = 1250000,
    parameter int unsigned RETRIGGER  = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic event_i,
    output logic led_o,
    output logic busy_o
);

    localparam int unsigned     CntW    = cnt_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [CntW-1:0] OnLoad  = CntW'(ON_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad = (GAP_CYCLES > 0) ? CntW'(GAP_CYCLES - 1) : '0;
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    led_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            led_q, led_d;
    logic            busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            StIdle: begin
                if (event_i) begin
                    state_d = StOn;
                    cnt_d   = OnLoad;
                    pend_d  = 1'b0;
                end
            end
            StOn: begin
                if ((RETRIGGER != 0) && event_i) begin
                    cnt_d = OnLoad;
                end else if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        cnt_d   = GapLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StGap: begin
                if (event_i) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    // Events seen anywhere in the gap collapse into one relight.
                    if (pend_q || event_i) begin
                        state_d = StOn;
                        cnt_d   = OnLoad;
                    end else begin
                        state_d = StIdle;
                    end
                    pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Outputs decoded from the next state so they are flops aligned with state_q.
    always_comb begin
        led_d  = (state_d == StOn);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Multi-channel LED pulse stretcher: NUM_CH independent stretch channels
// sharing one clock and synchronous reset.
module led_pulse_stretcher
    import led_pkg::*;
#(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned ON_CYCLES  = 2500000,
    parameter int unsigned GAP_CYCLES = 1250000,
    parameter int unsigned RETRIGGER  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] Event,
    output logic [NUM_CH-1:0] Led,
    output logic [NUM_CH-1:0] Busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_stretch_channel #(
            .ON_CYCLES (ON_CYCLES),
            .GAP_CYCLES(GAP_CYCLES),
            .RETRIGGER (RETRIGGER)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .event_i(Event[i]),
            .led_o  (Led[i]),
            .busy_o (Busy[i])
        );
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher: per-cycle vector table on the main
// configuration plus short sequences for the no-retrigger and zero-gap variants.
module tb_led_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ev;
    logic [7:0] led, busy;
    logic [7:0] led_nr, busy_nr;
    logic [1:0] led_s, busy_s;

    always #5 clk = ~clk;

    led_pulse_stretcher #(
        .NUM_CH(8), .ON_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1)
    ) dut (
        .clock(clk), .reset(rst), .Event(ev), .Led(led), .Busy(busy)
    );

    led_pulse_stretcher #(
        .NUM_CH(8), .ON_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0)
    ) dut_nr (
        .clock(clk), .reset(rst), .Event(ev), .Led(led_nr), .Busy(busy_nr)
    );

    led_pulse_stretcher #(
        .NUM_CH(2), .ON_CYCLES(1), .GAP_CYCLES(0), .RETRIGGER(1)
    ) dut_s (
        .clock(clk), .reset(rst), .Event(ev[1:0]), .Led(led_s), .Busy(busy_s)
    );

    // led/busy are the values expected just before the edge that samples rst/ev.
    typedef struct {
        logic       rst;
        logic [7:0] ev;
        logic [7:0] led;
        logic [7:0] busy;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(input logic r, input logic [7:0] e, input logic [7:0] l,
                                input logic [7:0] b, input int n);
        vec_t v;
        v.rst  = r;
        v.ev   = e;
        v.led  = l;
        v.busy = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ev  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ev  = 8'h00;
        repeat (3) @(negedge clk);

        // reset wins over a simultaneous event
        add(1, 8'hFF, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h00, 8'h00, 2);
        // isolated event
        add(0, 8'h01, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h01, 8'h01, 4);
        add(0, 8'h00, 8'h00, 8'h01, 2); add(0, 8'h00, 8'h00, 8'h00, 2);
        // retrigger mid-ON
        add(0, 8'h01, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h01, 8'h01, 1);
        add(0, 8'h01, 8'h01, 8'h01, 1); add(0, 8'h00, 8'h01, 8'h01, 4);
        add(0, 8'h00, 8'h00, 8'h01, 2); add(0, 8'h00, 8'h00, 8'h00, 2);
        // retrigger in the count=0 cycle keeps ON
        add(0, 8'h01, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h01, 8'h01, 3);
        add(0, 8'h01, 8'h01, 8'h01, 1); add(0, 8'h00, 8'h01, 8'h01, 4);
        add(0, 8'h00, 8'h00, 8'h01, 2); add(0, 8'h00, 8'h00, 8'h00, 2);
        // event early in GAP is held pending
        add(0, 8'h01, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h01, 8'h01, 4);
        add(0, 8'h01, 8'h00, 8'h01, 1); add(0, 8'h00, 8'h00, 8'h01, 1);
        add(0, 8'h00, 8'h01, 8'h01, 4); add(0, 8'h00, 8'h00, 8'h01, 2);
        add(0, 8'h00, 8'h00, 8'h00, 2);
        // two GAP events collapse into one relight
        add(0, 8'h01, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h01, 8'h01, 4);
        add(0, 8'h01, 8'h00, 8'h01, 2); add(0, 8'h00, 8'h01, 8'h01, 4);
        add(0, 8'h00, 8'h00, 8'h01, 2); add(0, 8'h00, 8'h00, 8'h00, 2);
        // event only in the last GAP cycle
        add(0, 8'h01, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h01, 8'h01, 4);
        add(0, 8'h00, 8'h00, 8'h01, 1); add(0, 8'h01, 8'h00, 8'h01, 1);
        add(0, 8'h00, 8'h01, 8'h01, 4); add(0, 8'h00, 8'h00, 8'h01, 2);
        add(0, 8'h00, 8'h00, 8'h00, 2);
        // all channels together
        add(0, 8'hFF, 8'h00, 8'h00, 1); add(0, 8'h00, 8'hFF, 8'hFF, 4);
        add(0, 8'h00, 8'h00, 8'hFF, 2); add(0, 8'h00, 8'h00, 8'h00, 2);
        // staggered channels 0 and 1 stay independent
        add(0, 8'h01, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h01, 8'h01, 1);
        add(0, 8'h02, 8'h01, 8'h01, 1); add(0, 8'h00, 8'h03, 8'h03, 2);
        add(0, 8'h00, 8'h02, 8'h03, 2); add(0, 8'h00, 8'h00, 8'h02, 2);
        add(0, 8'h00, 8'h00, 8'h00, 2);
        // reset mid-ON together with an event, then a fresh event
        add(0, 8'h08, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h08, 8'h08, 1);
        add(1, 8'h08, 8'h08, 8'h08, 1); add(0, 8'h00, 8'h00, 8'h00, 7);
        add(0, 8'h08, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h08, 8'h08, 4);
        add(0, 8'h00, 8'h00, 8'h08, 2); add(0, 8'h00, 8'h00, 8'h00, 2);
        // reset in GAP drops the pending relight
        add(0, 8'h01, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h01, 8'h01, 4);
        add(0, 8'h01, 8'h00, 8'h01, 1); add(1, 8'h00, 8'h00, 8'h01, 1);
        add(0, 8'h00, 8'h00, 8'h00, 4);
        add(0, 8'h01, 8'h00, 8'h00, 1); add(0, 8'h00, 8'h01, 8'h01, 4);
        add(0, 8'h00, 8'h00, 8'h01, 2); add(0, 8'h00, 8'h00, 8'h00, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check8($sformatf("row%0d led", i), led, vecs[i].led);
            check8($sformatf("row%0d busy", i), busy, vecs[i].busy);
            rst = vecs[i].rst;
            ev  = vecs[i].ev;
        end

        // RETRIGGER=0: event at c=0 and c=2; the second is ignored, no relight
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check8($sformatf("nr c%0d led", c), {7'b0, led_nr[0]},
                   {7'b0, (c >= 1 && c <= 4)});
            check8($sformatf("nr c%0d busy", c), {7'b0, busy_nr[0]},
                   {7'b0, (c >= 1 && c <= 6)});
            ev = (c == 0 || c == 2) ? 8'h01 : 8'h00;
        end

        // ON_CYCLES=1, GAP_CYCLES=0: ch0 single event, ch1 back-to-back events
        do_reset();
        for (int c = 0; c < 7; c++) begin
            logic [7:0] exp_s;
            exp_s = {6'b0, (c == 3 || c == 4), (c == 1)};
            @(negedge clk);
            check8($sformatf("s c%0d led", c), {6'b0, led_s}, exp_s);
            check8($sformatf("s c%0d busy", c), {6'b0, busy_s}, exp_s);
            ev = {6'b0, (c == 2 || c == 3), (c == 0)};
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
